// File: rtl/ecpri_intr_pkg.sv
// Shared definitions for the eCPRI interrupt controller: register word offsets,
// AXI response codes, per-source sensitivity type and a byte-strobe helper.
package ecpri_intr_pkg;

    // Register word index, i.e. byte address bits [4:2]
    localparam logic [2:0] RegGie = 3'd0;
    localparam logic [2:0] RegIer = 3'd1;
    localparam logic [2:0] RegIsr = 3'd2;
    localparam logic [2:0] RegIar = 3'd3;
    localparam logic [2:0] RegIpr = 3'd4;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlverr = 2'b10
    } axi_resp_e;

    typedef enum logic {
        SensLevel = 1'b0,
        SensEdge  = 1'b1
    } intr_sens_t;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ecpri_intr_capture.sv
// One interrupt source: edge or level detection feeding a sticky status bit.
// A set condition in the same cycle as a clear keeps the bit set.
module ecpri_intr_capture
    import ecpri_intr_pkg::*;
#(
    parameter intr_sens_t Sens = SensEdge
) (
    input  logic clk,
    input  logic rst_n,
    input  logic intr_in,
    input  logic clr,
    output logic status
);

    logic prev_q;
    logic status_q;
    logic set;

    // Set condition: rising edge against the registered previous value, or plain level
    always_comb begin
        set = (Sens == SensEdge) ? (intr_in & ~prev_q) : intr_in;
    end

    // Previous-value tracking and sticky status with set priority over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            prev_q   <= intr_in;
            status_q <= set | (status_q & ~clr);
        end
    end

    assign status = status_q;

endmodule

// File: rtl/ecpri_intr_ctrl.sv
// AXI4-Lite interrupt controller: status capture, per-source and global enables,
// write-one-to-clear acknowledge and a registered irq output.
module ecpri_intr_ctrl
    import ecpri_intr_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned C_NUM_OF_INTR      = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFF_FFFF,
    parameter bit          C_IRQ_ACTIVE_STATE = 1'b1
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_NUM_OF_INTR-1:0]        intr_in,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);

    // Implemented source bits; a shift by 32 yields 0, so 0 - 1 gives all ones
    localparam logic [31:0] SrcMask = (32'd1 << C_NUM_OF_INTR) - 32'd1;

    logic        aw_held_q, w_held_q, bvalid_q, rvalid_q, gie_q, irq_q;
    logic [2:0]  aw_idx_q;
    logic [31:0] w_data_q, rdata_q, ier_q;
    logic [3:0]  w_strb_q;

    logic        aw_fire, w_fire, ar_fire, wr_en;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data, wr_mask, iar_clr, isr_w, rd_data;

    // Ready is forced low while reset is asserted
    assign S_AXI_AWREADY = ARESETN & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = ARESETN & ~w_held_q & ~bvalid_q;
    assign S_AXI_ARREADY = ARESETN & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RespOkay;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RespOkay;
    assign irq           = C_IRQ_ACTIVE_STATE ? irq_q : ~irq_q;

    // Write path: combine held and just-arriving address/data so a write can complete
    // on the edge where the second half arrives
    always_comb begin
        aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
        w_fire  = S_AXI_WVALID & S_AXI_WREADY;
        ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;
        wr_en   = (aw_held_q | aw_fire) & (w_held_q | w_fire);
        wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[4:2];
        wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
        wr_mask = strb_mask(w_held_q ? w_strb_q : S_AXI_WSTRB);
        iar_clr = (wr_en && wr_idx == RegIar) ? (wr_data & wr_mask) : 32'd0;
    end

    for (genvar i = 0; i < 32; i++) begin : g_src
        if (i < C_NUM_OF_INTR) begin : g_cap
            ecpri_intr_capture #(
                .Sens (intr_sens_t'(C_INTR_SENSITIVITY[i]))
            ) u_cap (
                .clk     (ACLK),
                .rst_n   (ARESETN),
                .intr_in (intr_in[i]),
                .clr     (iar_clr[i]),
                .status  (isr_w[i])
            );
        end else begin : g_tie
            assign isr_w[i] = 1'b0;
        end
    end

    // Read data mux over the current register contents
    always_comb begin
        rd_data = 32'd0;
        case (S_AXI_ARADDR[4:2])
            RegGie:  rd_data = {31'd0, gie_q};
            RegIer:  rd_data = ier_q;
            RegIsr:  rd_data = isr_w;
            RegIpr:  rd_data = isr_w & ier_q;
            default: rd_data = 32'd0;
        endcase
    end

    // Write channel handshake: hold AW/W halves, issue the response when both are present
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= 3'd0;
            w_held_q  <= 1'b0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            bvalid_q  <= 1'b0;
        end else begin
            if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (wr_en) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
            end else begin
                if (aw_fire) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= S_AXI_AWADDR[4:2];
                end
                if (w_fire) begin
                    w_held_q <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end
        end
    end

    // RW register file with byte strobes; bits beyond the source count stay 0
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gie_q <= 1'b0;
            ier_q <= 32'd0;
        end else if (wr_en) begin
            if (wr_idx == RegGie && wr_mask[0]) begin
                gie_q <= wr_data[0];
            end
            if (wr_idx == RegIer) begin
                ier_q <= ((ier_q & ~wr_mask) | (wr_data & wr_mask)) & SrcMask;
            end
        end
    end

    // Read channel: register data on AR handshake, hold until RREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
            end
        end
    end

    // Interrupt request from the registered pending state, one cycle behind ISR
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= gie_q & |(isr_w & ier_q);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           iar_clr};

endmodule

// File: tb/tb_ecpri_intr_ctrl.sv
// Directed bench for ecpri_intr_ctrl with four sources, source 2 level-sensitive.
module tb_ecpri_intr_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  intr_in;
    logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY, irq;

    int total = 0;
    int bad = 0;
    logic irq_at_b;
    logic [31:0] rd;

    ecpri_intr_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .C_NUM_OF_INTR      (4),
        .C_INTR_SENSITIVITY (32'hFFFF_FFFB),
        .C_IRQ_ACTIVE_STATE (1'b1)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .intr_in       (intr_in),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .irq           (irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic aw_ok, w_ok;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
            @(negedge ACLK);
            aw_ok = S_AXI_AWVALID & S_AXI_AWREADY;
            w_ok  = S_AXI_WVALID & S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_ok) S_AXI_AWVALID = 1'b0;
            if (w_ok) S_AXI_WVALID = 1'b0;
            n++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk($sformatf("wr_bvalid_%h", a), 32'(S_AXI_BVALID), 32'd1);
        chk($sformatf("wr_bresp_%h", a), 32'(S_AXI_BRESP), 32'd0);
        irq_at_b = irq;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        chk($sformatf("wr_bdone_%h", a), 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        logic ok;
        @(posedge ACLK); #1;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        n = 0; ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge ACLK);
            ok = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        chk($sformatf("rd_rvalid_%h", a), 32'(S_AXI_RVALID), 32'd1);
        chk($sformatf("rd_rresp_%h", a), 32'(S_AXI_RRESP), 32'd0);
        d = S_AXI_RDATA;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        ARESETN = 1'b0; intr_in = 4'd0;
        S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_BREADY = 1'b0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

        // 1: reset state and full register sweep
        #3;
        chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        chk("rst_wready", 32'(S_AXI_WREADY), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            axi_read(5'(i * 4), rd);
            chk($sformatf("sweep_%0d", i * 4), rd, 32'd0);
        end
        chk("sweep_irq", 32'(irq), 32'd0);

        // 2: enabled pulse raises irq two edges later; IAR clears it
        axi_write(5'h00, 32'd1, 4'hF);
        axi_write(5'h04, 32'd1, 4'hF);
        @(posedge ACLK); #1 intr_in[0] = 1'b1;
        @(posedge ACLK); #1 intr_in[0] = 1'b0;
        chk("t2_irq_t", 32'(irq), 32'd0);
        @(posedge ACLK); #1;
        chk("t2_irq_t1", 32'(irq), 32'd1);
        axi_read(5'h08, rd); chk("t2_isr", rd, 32'd1);
        axi_read(5'h10, rd); chk("t2_ipr", rd, 32'd1);
        axi_write(5'h0C, 32'd1, 4'hF);
        chk("t2_irq_at_b", 32'(irq_at_b), 32'd1);
        chk("t2_irq_clr", 32'(irq), 32'd0);
        axi_read(5'h10, rd); chk("t2_ipr_clr", rd, 32'd0);
        axi_read(5'h0C, rd); chk("t2_iar_rd", rd, 32'd0);

        // 3: GIE off captures but holds irq low; enabling GIE raises it
        axi_write(5'h00, 32'd0, 4'hF);
        @(posedge ACLK); #1 intr_in[0] = 1'b1;
        @(posedge ACLK); #1 intr_in[0] = 1'b0;
        @(posedge ACLK); #1;
        chk("t3_irq_off", 32'(irq), 32'd0);
        axi_read(5'h08, rd); chk("t3_isr", rd, 32'd1);
        axi_write(5'h00, 32'd1, 4'hF);
        chk("t3_irq_at_b", 32'(irq_at_b), 32'd0);
        chk("t3_irq_on", 32'(irq), 32'd1);

        // 4: IAR clear coinciding with a new edge on source 0 -- set wins
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'd1; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1; intr_in[0] = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; intr_in[0] = 1'b0;
        chk("t4_bvalid", 32'(S_AXI_BVALID), 32'd1);
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        chk("t4_bdone", 32'(S_AXI_BVALID), 32'd0);
        chk("t4_irq", 32'(irq), 32'd1);
        axi_read(5'h08, rd); chk("t4_isr", rd, 32'd1);
        axi_write(5'h0C, 32'd1, 4'hF);
        chk("t4_irq_clr", 32'(irq), 32'd0);

        // 5: W three cycles ahead of AW, BREADY held off, concurrent read of IER
        @(posedge ACLK); #1;
        S_AXI_WDATA = 32'd5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        chk("t5_wready_held", 32'(S_AXI_WREADY), 32'd0);
        chk("t5_awready", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge ACLK); #1;
        chk("t5_no_b1", 32'(S_AXI_BVALID), 32'd0);
        @(posedge ACLK); #1;
        chk("t5_no_b2", 32'(S_AXI_BVALID), 32'd0);
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("t5_bvalid", 32'(S_AXI_BVALID), 32'd1);
        chk("t5_rvalid", 32'(S_AXI_RVALID), 32'd1);
        chk("t5_rd_old_ier", S_AXI_RDATA, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            chk($sformatf("t5_bhold_%0d", i), 32'(S_AXI_BVALID), 32'd1);
            chk($sformatf("t5_awblk_%0d", i), 32'(S_AXI_AWREADY), 32'd0);
        end
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        chk("t5_bdone", 32'(S_AXI_BVALID), 32'd0);
        chk("t5_rdone", 32'(S_AXI_RVALID), 32'd0);
        axi_read(5'h04, rd); chk("t5_ier_new", rd, 32'd5);

        // 6: level source survives IAR while high, clears after it drops
        @(posedge ACLK); #1 intr_in[2] = 1'b1;
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h08, rd); chk("t6_isr_lvl", rd, 32'h4);
        axi_read(5'h10, rd); chk("t6_ipr_lvl", rd, 32'h4);
        chk("t6_irq_lvl", 32'(irq), 32'd1);
        intr_in[2] = 1'b0;
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h08, rd); chk("t6_isr_clr", rd, 32'd0);
        chk("t6_irq_clr", 32'(irq), 32'd0);

        // strobes, unimplemented bits and ignored writes
        axi_write(5'h04, 32'hFFFF_FFFF, 4'b0010);
        axi_read(5'h04, rd); chk("strb_ier_b1", rd, 32'd5);
        axi_write(5'h04, 32'hFFFF_FFFA, 4'b0001);
        axi_read(5'h04, rd); chk("strb_ier_b0", rd, 32'hA);
        axi_write(5'h08, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h08, rd); chk("isr_ro", rd, 32'd0);
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h18, rd); chk("rsvd_rd", rd, 32'd0);

        // reset mid-read, with an edge source held high through reset
        @(posedge ACLK); #1;
        intr_in[0] = 1'b1;
        S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        chk("rst_rd_rvalid", 32'(S_AXI_RVALID), 32'd1);
        #2 ARESETN = 1'b0;
        #1;
        chk("rst_rd_drop", 32'(S_AXI_RVALID), 32'd0);
        chk("rst_rd_rdata", S_AXI_RDATA, 32'd0);
        chk("rst_rd_awready", 32'(S_AXI_AWREADY), 32'd0);
        chk("rst_rd_irq", 32'(irq), 32'd0);
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        axi_read(5'h08, rd); chk("rst_edge_isr", rd, 32'd1);
        axi_read(5'h00, rd); chk("rst_gie", rd, 32'd0);
        axi_read(5'h04, rd); chk("rst_ier", rd, 32'd0);
        intr_in = 4'd0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
